// File: rtl/lu_pkg.sv
// Shared constants for the nibble-serial logic unit: sizes, opcodes and FSM states.
package lu_pkg;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 4;
  localparam int N_SLICE = DATA_W / SLICE_W;
  localparam int CNT_W   = $clog2(N_SLICE);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Opcodes above XNOR have no gate cell behind them.
  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_XNOR;
  endfunction

endpackage

// File: rtl/_and2_4bits.sv
// 4-bit two-input AND gate cell.
module _and2_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

// File: rtl/_inv_4bits.sv
// 4-bit inverter gate cell.
module _inv_4bits (
  input  logic [3:0] a_i,
  output logic [3:0] y_o
);
  assign y_o = ~a_i;
endmodule

// File: rtl/_or2_4bits.sv
// 4-bit two-input OR gate cell.
module _or2_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/_xnor2_4bits.sv
// 4-bit two-input XNOR gate cell.
module _xnor2_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);
  assign y_o = ~(a_i ^ b_i);
endmodule

// File: rtl/_xor2_4bits.sv
// 4-bit two-input XOR gate cell.
module _xor2_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule

// File: rtl/lu_slice4.sv
// Shared 4-bit gate slice: all five gate cells see the same nibble, op picks one.
module lu_slice4
  import lu_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);

  logic [3:0] inv_y;
  logic [3:0] and_y;
  logic [3:0] or_y;
  logic [3:0] xor_y;
  logic [3:0] xnor_y;

  _inv_4bits   u_inv  (.a_i(a_i),              .y_o(inv_y));
  _and2_4bits  u_and  (.a_i(a_i), .b_i(b_i),   .y_o(and_y));
  _or2_4bits   u_or   (.a_i(a_i), .b_i(b_i),   .y_o(or_y));
  _xor2_4bits  u_xor  (.a_i(a_i), .b_i(b_i),   .y_o(xor_y));
  _xnor2_4bits u_xnor (.a_i(a_i), .b_i(b_i),   .y_o(xnor_y));

  always_comb begin
    y_o = 4'b0000;
    case (op_i)
      OP_NOT:  y_o = inv_y;
      OP_AND:  y_o = and_y;
      OP_OR:   y_o = or_y;
      OP_XOR:  y_o = xor_y;
      OP_XNOR: y_o = xnor_y;
      default: y_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/lu_nibble_seq.sv
// Nibble-serial logic unit controller: latches one op, walks the shared slice over
// eight nibbles LSB first, then pulses done (with err for illegal opcodes).
module lu_nibble_seq
  import lu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        state_dbg
);

  // Handshake: start is taken only in IDLE or DONE (start beats abort in DONE);
  // there is no ready, so the caller must hold off while busy is high.

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                accept;
  logic                last_slice;
  logic [N_SLICE-1:0]  nib_we;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_y;

  assign slice_a    = a_q[cnt_q*SLICE_W +: SLICE_W];
  assign slice_b    = b_q[cnt_q*SLICE_W +: SLICE_W];
  assign last_slice = (cnt_q == CNT_W'(N_SLICE - 1));
  assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);

  lu_slice4 u_slice (
    .op_i (op_q),
    .a_i  (slice_a),
    .b_i  (slice_b),
    .y_o  (slice_y)
  );

  // One-hot nibble write enable; the slice is still written on an abort cycle.
  always_comb begin
    nib_we = '0;
    for (int i = 0; i < N_SLICE; i++) begin
      nib_we[i] = (state_q == S_RUN) && (cnt_q == CNT_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    for (int i = 0; i < N_SLICE; i++) begin
      if (nib_we[i]) begin
        result_d[i*SLICE_W +: SLICE_W] = slice_y;
      end
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_slice) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d  = S_RUN;
      cnt_d    = '0;
      op_d     = op;
      a_d      = a;
      b_d      = b;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && op_illegal(op_q);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lu_nibble_seq.sv
// Bench for lu_nibble_seq: driver tasks push expected {err,result} and done cycle,
// a negedge monitor pops and compares whenever done is presented.
module tb_lu_nibble_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  int          cyc;
  int          n_checks;
  int          n_fail;

  lu_nibble_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: whole-word bitwise semantics of each opcode.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    case (o)
      3'd0:    return ~x;
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return x ^ y;
      3'd4:    return ~(x ^ y);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] o);
    return o > 3'd4;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 64'(done), 64'(0));
      end else begin
        logic [32:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", 64'(result), 64'(e[31:0]));
        check("err", 64'(err), 64'(e[32]));
        check("done cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    op = 3'($urandom_range(0, 7));
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) begin
      exp_q.push_back({ref_err(o), ref_result(o, x, y)});
      exp_cyc_q.push_back(cyc + 9);
    end
  endtask

  task automatic run_plain(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input bit chk_busy);
    int busy_cnt;
    issue(o, x, y, 1'b1);
    tick();
    start = 1'b0;
    scramble();
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (busy) busy_cnt++;
      tick();
    end
    if (chk_busy) check("busy cycles", 64'(busy_cnt), 64'(8));
  endtask

  // start held through RUN (with changing operands) and DONE; second op follows with no IDLE gap.
  task automatic run_b2b(input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                         input logic [2:0] o2, input logic [31:0] x2, input logic [31:0] y2,
                         input bit abort_in_done);
    issue(o1, x1, y1, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      scramble();
      tick();
    end
    check("in done before b2b", 64'(done), 64'(1));
    issue(o2, x2, y2, 1'b1);
    abort = abort_in_done;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("b2b busy no idle gap", 64'(busy), 64'(1));
    scramble();
    repeat (9) tick();
  endtask

  task automatic run_abort(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input int k);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < k; i++) mask[i*4 +: 4] = 4'hF;
    issue(o, x, y, 1'b0);
    tick();
    start = 1'b0;
    scramble();
    repeat (k - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort partial result", 64'(result), 64'(ref_result(o, x, y) & mask));
    repeat (3) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    repeat (3) tick();
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset err", 64'(err), 64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset state", 64'(state_dbg), 64'(0));
    reset_n = 1'b1;
    tick();

    run_plain(3'b001, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1);
    run_plain(3'b000, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    run_plain(3'b100, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
    run_b2b(3'b011, 32'hDEADBEEF, 32'hFFFFFFFF, 3'b010, 32'h00F0F000, 32'h0F000F0F, 1'b0);
    run_plain(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_plain(3'b010, 32'h00000001, 32'h00000002, 1'b0);

    // abort while idle must not disturb anything
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    check("idle abort busy", 64'(busy), 64'(0));

    run_abort(3'b010, 32'hFFFFFFFF, 32'h00000000, 4);
    run_abort(3'b010, 32'hFFFFFFFF, 32'h00000000, 8);
    run_abort(3'b011, $urandom, $urandom, 2);

    // reset in the fifth RUN cycle
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid reset busy", 64'(busy), 64'(0));
    check("mid reset done", 64'(done), 64'(0));
    check("mid reset result", 64'(result), 64'(0));
    tick();
    run_plain(3'b011, 32'h0000FFFF, 32'h00FF00FF, 1'b1);

    run_b2b(3'b111, $urandom, $urandom, 3'b000, $urandom, $urandom, 1'b1);

    for (int n = 0; n < 16; n++) begin
      logic [2:0]  o1, o2;
      logic [31:0] x1, y1, x2, y2;
      o1 = 3'($urandom_range(0, 7));
      o2 = 3'($urandom_range(0, 7));
      x1 = $urandom;
      y1 = $urandom;
      x2 = $urandom;
      y2 = $urandom;
      if ($urandom_range(0, 1) == 0) run_plain(o1, x1, y1, 1'b1);
      else run_b2b(o1, x1, y1, o2, x2, y2, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
